radix5_input_gather: RTL and testbench

Serial-to-parallel front end for the radix-5 butterfly pipeline. It collects a stream of complex single-precision samples, one per accepted cycle, into 5-point frames. Each completed frame is presented as five registered complex outputs x0..x4; the a/b/c operand inputs of the downstream radix-5 partial stages are wired from these outputs. It also carries a frame tag alongside a valid bit through a delay line equal to the downstream latency, so downstream results can be qualified.

---
 rtl/radix5_pkg.sv | 16 +
 rtl/tag_delay.sv | 30 +++
 rtl/radix5_input_gather.sv | 117 +++++++++++
 tb/tb_radix5_input_gather.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/radix5_pkg.sv
// Shared types and sizes for the radix-5 butterfly pipeline.
// Sample width, points per frame and slot-counter sizing live here so every stage agrees.
package radix5_pkg;

    localparam int DW     = 32;
    localparam int NPTS   = 5;
    localparam int SLOT_W = 3;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NPTS - 1);

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] img;
    } complex_t;

endpackage

// File: rtl/tag_delay.sv
// Fixed-depth shift register carrying a tag word; q is d delayed by DEPTH cycles.
// Advances every cycle with no stall input; synchronous active-low clear empties every stage.
module tag_delay #(
    parameter int DEPTH = 9,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/radix5_input_gather.sv
// Gathers one complex sample per valid cycle into 5-point frames, held on x0..x4 one cycle after the 5th sample.
// No backpressure: every valid sample is accepted; a frame tag follows out_valid through a DS_LAT delay line.
module radix5_input_gather #(
    parameter int DW     = radix5_pkg::DW,
    parameter int DS_LAT = 9,
    parameter int FCW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic           in_sync,
    input  logic [DW-1:0]  in_re,
    input  logic [DW-1:0]  in_img,
    output logic [DW-1:0]  x0_re,
    output logic [DW-1:0]  x1_re,
    output logic [DW-1:0]  x2_re,
    output logic [DW-1:0]  x3_re,
    output logic [DW-1:0]  x4_re,
    output logic [DW-1:0]  x0_img,
    output logic [DW-1:0]  x1_img,
    output logic [DW-1:0]  x2_img,
    output logic [DW-1:0]  x3_img,
    output logic [DW-1:0]  x4_img,
    output logic           out_valid,
    output logic [FCW-1:0] out_frame,
    output logic           frame_drop,
    output logic           ds_valid,
    output logic [FCW-1:0] ds_frame
);

    import radix5_pkg::*;

    logic [SLOT_W-1:0] slot;
    logic [FCW-1:0]    frame_cnt;

    // Slot NPTS-1 is never captured: the completing sample goes straight to the output bank.
    logic [DW-1:0] cap_re  [NPTS-1];
    logic [DW-1:0] cap_img [NPTS-1];
    logic [DW-1:0] x_re    [NPTS];
    logic [DW-1:0] x_img   [NPTS];

    logic [FCW:0]  ds_tag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot       <= '0;
            frame_cnt  <= '0;
            out_frame  <= '0;
            out_valid  <= 1'b0;
            frame_drop <= 1'b0;
            for (int i = 0; i < NPTS - 1; i++) begin
                cap_re[i]  <= '0;
                cap_img[i] <= '0;
            end
            for (int i = 0; i < NPTS; i++) begin
                x_re[i]  <= '0;
                x_img[i] <= '0;
            end
        end else begin
            out_valid  <= 1'b0;
            frame_drop <= 1'b0;
            if (in_valid) begin
                // A sync always restarts the frame, even when it lands on the completing slot.
                if (in_sync) begin
                    cap_re[0]  <= in_re;
                    cap_img[0] <= in_img;
                    slot       <= SLOT_W'(1);
                    frame_drop <= (slot != '0);
                end else if (slot == LAST_SLOT) begin
                    for (int i = 0; i < NPTS - 1; i++) begin
                        x_re[i]  <= cap_re[i];
                        x_img[i] <= cap_img[i];
                    end
                    x_re[NPTS-1]  <= in_re;
                    x_img[NPTS-1] <= in_img;
                    out_valid     <= 1'b1;
                    out_frame     <= frame_cnt;
                    frame_cnt     <= frame_cnt + 1'b1;
                    slot          <= '0;
                end else begin
                    for (int i = 0; i < NPTS - 1; i++) begin
                        if (slot == SLOT_W'(i)) begin
                            cap_re[i]  <= in_re;
                            cap_img[i] <= in_img;
                        end
                    end
                    slot <= slot + 1'b1;
                end
            end
        end
    end

    assign x0_re  = x_re[0];
    assign x1_re  = x_re[1];
    assign x2_re  = x_re[2];
    assign x3_re  = x_re[3];
    assign x4_re  = x_re[4];
    assign x0_img = x_img[0];
    assign x1_img = x_img[1];
    assign x2_img = x_img[2];
    assign x3_img = x_img[3];
    assign x4_img = x_img[4];

    tag_delay #(
        .DEPTH (DS_LAT),
        .W     (FCW + 1)
    ) u_tag_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({out_valid, out_frame}),
        .q     (ds_tag)
    );

    assign ds_valid = ds_tag[FCW];
    assign ds_frame = ds_tag[FCW-1:0];

endmodule

// File: tb/tb_radix5_input_gather.sv
// Directed bench for radix5_input_gather: framing, gaps, sync drops, reset, tag delay and counter wrap.
// Inputs change #1 after the rising edge; outputs are compared at that same point.
module tb_radix5_input_gather;

    localparam int DW     = 32;
    localparam int DS_LAT = 9;
    localparam int FCW    = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_sync;
    logic [DW-1:0]  in_re;
    logic [DW-1:0]  in_img;
    logic [DW-1:0]  x0_re, x1_re, x2_re, x3_re, x4_re;
    logic [DW-1:0]  x0_img, x1_img, x2_img, x3_img, x4_img;
    logic           out_valid;
    logic [FCW-1:0] out_frame;
    logic           frame_drop;
    logic           ds_valid;
    logic [FCW-1:0] ds_frame;

    logic [DW-1:0]  xr [5];
    logic [DW-1:0]  xi [5];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    radix5_input_gather #(
        .DW     (DW),
        .DS_LAT (DS_LAT),
        .FCW    (FCW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sync    (in_sync),
        .in_re      (in_re),
        .in_img     (in_img),
        .x0_re      (x0_re),
        .x1_re      (x1_re),
        .x2_re      (x2_re),
        .x3_re      (x3_re),
        .x4_re      (x4_re),
        .x0_img     (x0_img),
        .x1_img     (x1_img),
        .x2_img     (x2_img),
        .x3_img     (x3_img),
        .x4_img     (x4_img),
        .out_valid  (out_valid),
        .out_frame  (out_frame),
        .frame_drop (frame_drop),
        .ds_valid   (ds_valid),
        .ds_frame   (ds_frame)
    );

    assign xr[0] = x0_re;
    assign xr[1] = x1_re;
    assign xr[2] = x2_re;
    assign xr[3] = x3_re;
    assign xr[4] = x4_re;
    assign xi[0] = x0_img;
    assign xi[1] = x1_img;
    assign xi[2] = x2_img;
    assign xi[3] = x3_img;
    assign xi[4] = x4_img;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every sample carries img = -re so both components are checked from one number.
    task automatic step(input logic v, input logic s, input logic [31:0] re);
        in_valid = v;
        in_sync  = s;
        in_re    = re;
        in_img   = 32'd0 - re;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_frame(input string tag, input logic [31:0] base, input logic [FCW-1:0] fr);
        logic [31:0] er;
        logic [31:0] ei;
        for (int i = 0; i < 5; i++) begin
            er = base + 32'(i);
            ei = 32'd0 - er;
            chk({tag, "_re"}, 64'(xr[i]), 64'(er));
            chk({tag, "_img"}, 64'(xi[i]), 64'(ei));
        end
        chk({tag, "_frame"}, 64'(out_frame), 64'(fr));
    endtask

    initial begin
        logic [FCW-1:0] ef;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sync = 1'b0;
        in_re = '0;
        in_img = '0;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_frame_drop", 64'(frame_drop), 64'd0);
        chk("rst_ds_valid", 64'(ds_valid), 64'd0);
        chk("rst_ds_frame", 64'(ds_frame), 64'd0);
        chk("rst_out_frame", 64'(out_frame), 64'd0);
        chk("rst_x0_re", 64'(x0_re), 64'd0);
        chk("rst_x4_img", 64'(x4_img), 64'd0);
        rst_n = 1'b1;

        // Contiguous stream k=0..9
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 32'(k));
            chk("c_out_valid", 64'(out_valid), 64'((k % 5) == 4));
            chk("c_ds_quiet", 64'(ds_valid), 64'd0);
            if (k == 4) chk_frame("c_f0", 32'd0, 8'd0);
            if (k == 9) chk_frame("c_f1", 32'd5, 8'd1);
            if (k >= 5 && k <= 8) chk("c_hold", 64'(x0_re), 64'd0);
        end
        // Frame 0 valid 5 cycles before the last sample edge; its tag emerges 9 cycles after out_valid.
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0);
            chk("ds_valid", 64'(ds_valid), 64'(i == 3 || i == 8));
            chk("ds_out_idle", 64'(out_valid), 64'd0);
            if (i == 3) chk("ds_frame0", 64'(ds_frame), 64'd0);
            if (i == 8) chk("ds_frame1", 64'(ds_frame), 64'd1);
        end

        // Same stream with two idle cycles after every sample
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 32'(k));
            chk("g_out_valid", 64'(out_valid), 64'((k % 5) == 4));
            if (k == 4) chk_frame("g_f2", 32'd0, 8'd2);
            if (k == 9) chk_frame("g_f3", 32'd5, 8'd3);
            for (int g = 0; g < 2; g++) begin
                step(0, 0, 0);
                chk("g_idle_valid", 64'(out_valid), 64'd0);
                chk("g_hold", 64'(x0_re), (k >= 4 && k < 9) ? 64'd0 : 64'd5);
            end
        end

        // Sync drops: mid-frame, on the completing slot, and harmless at slot 0
        rst_n = 1'b0;
        step(0, 0, 0);
        rst_n = 1'b1;
        step(1, 0, 50);
        step(1, 0, 51);
        step(1, 0, 52);
        step(1, 1, 100);
        chk("s3_drop", 64'(frame_drop), 64'd1);
        chk("s3_no_valid", 64'(out_valid), 64'd0);
        for (int k = 101; k <= 104; k++) begin
            step(1, 0, 32'(k));
            chk("s3_drop_clear", 64'(frame_drop), 64'd0);
        end
        chk("s3_valid", 64'(out_valid), 64'd1);
        chk_frame("s3_f0", 32'd100, 8'd0);

        for (int k = 200; k <= 203; k++) step(1, 0, 32'(k));
        step(1, 1, 210);
        chk("s4_drop", 64'(frame_drop), 64'd1);
        chk("s4_no_valid", 64'(out_valid), 64'd0);
        chk("s4_hold", 64'(x0_re), 64'd100);
        for (int k = 211; k <= 214; k++) step(1, 0, 32'(k));
        chk("s4_valid", 64'(out_valid), 64'd1);
        chk_frame("s4_f1", 32'd210, 8'd1);

        step(1, 1, 300);
        chk("s0_no_drop", 64'(frame_drop), 64'd0);
        step(1, 0, 301);
        step(0, 1, 999);
        chk("sync_no_valid_ignored", 64'(frame_drop), 64'd0);
        step(1, 0, 302);
        step(1, 0, 303);
        step(1, 0, 304);
        chk("s0_valid", 64'(out_valid), 64'd1);
        chk_frame("s0_f2", 32'd300, 8'd2);

        // Reset mid-frame
        step(1, 0, 400);
        step(1, 0, 401);
        rst_n = 1'b0;
        step(0, 0, 0);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_out_frame", 64'(out_frame), 64'd0);
        chk("mr_x0_re", 64'(x0_re), 64'd0);
        chk("mr_x4_img", 64'(x4_img), 64'd0);
        chk("mr_ds_valid", 64'(ds_valid), 64'd0);
        chk("mr_ds_frame", 64'(ds_frame), 64'd0);
        rst_n = 1'b1;
        for (int k = 10; k <= 14; k++) step(1, 0, 32'(k));
        chk("mr_valid", 64'(out_valid), 64'd1);
        chk_frame("mr_f0", 32'd10, 8'd0);

        // Frame counter wrap: frames 1..257 give out_frame 1..255, 0, 1
        for (int f = 1; f <= 257; f++) begin
            for (int j = 0; j < 5; j++) step(1, 0, 32'(1000 + j));
            ef = f[FCW-1:0];
            chk("w_valid", 64'(out_valid), 64'd1);
            chk("w_frame", 64'(out_frame), 64'(ef));
        end
        chk("w_x4_re", 64'(x4_re), 64'd1004);
        step(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
